y86_mem_arbiter: RTL and testbench
==================================

Name: y86_mem_arbiter

Overview:
- Shares the single 32-bit memory port between two requesters: the y86_seq core (instruction fetch, load, store) and a host/debug port (memory preload, inspection, DMA-style access).
- Fair round-robin arbitration, registered memory-side handshake, and a per-transaction timeout.
- Sits between the core's bus_A/bus_in/bus_out/bus_WE/bus_RE and the memory model.
- Stalls the core via cpu_stall while it waits.

Parameters:
- TIMEOUT, 16: cycles to wait for mem_ack before aborting; minimum 2.
- ERR_DATA, 32'hDEADBEEF: read data returned on an aborted transaction.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cpu_A  in  32  core address (bus_A)
- cpu_RE  in  1  core read request (bus_RE)
- cpu_WE  in  1  core write request (bus_WE)
- cpu_wdata  in  32  core write data (bus_out)
- cpu_rdata  out  32  read data to core (bus_in)
- cpu_stall  out  1  core must hold its request and freeze its phase ring
- host_req  in  1  host request, held until host_ack
- host_we  in  1  host write (1) / read (0)
- host_addr  in  32  host address
- host_wdata  in  32  host write data
- host_rdata  out  32  host read data, valid with host_ack
- host_ack  out  1  one-cycle completion pulse
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  32  memory address, registered
- mem_wdata  out  32  memory write data, registered
- mem_rdata  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle memory completion
- err  out  1  one-cycle pulse on timeout or on cpu_RE and cpu_WE both high

Behaviour:
- Reset (sync, high): state IDLE. All of the following are 0: mem_req, mem_we, mem_addr, mem_wdata, cpu_rdata, host_rdata, host_ack, err. last_grant = HOST, so the CPU wins the first tie. Timeout counter = 0.
- cpu_req = cpu_RE | cpu_WE.
- If cpu_RE and cpu_WE are both high, the transaction is treated as a write and err pulses when it is granted.
- States: IDLE, BUSY_CPU, BUSY_HOST.
- IDLE:
  - Only one requester active: grant it.
  - Both active: grant the one that is not last_grant.
  - On grant, at the next edge: latch mem_addr/mem_we/mem_wdata from the winner, set mem_req=1, update last_grant, clear the counter, enter BUSY_x.
  - Latency: request seen in IDLE in cycle N gives mem_req=1 in cycle N+1.
- BUSY_x:
  - mem_req and the mem_* signals are held stable; requester inputs are ignored.
  - Counter increments every cycle without mem_ack.
  - mem_ack: next edge drops mem_req and returns to IDLE. Reads register mem_rdata into cpu_rdata or host_rdata. Host transactions pulse host_ack for one cycle.
  - Counter reaches TIMEOUT-1 with no mem_ack: abort. mem_req drops, err pulses, requester gets ERR_DATA on reads, host_ack still pulses for host transactions, state returns to IDLE.
  - mem_ack arriving in the abort cycle wins; no err.
- cpu_stall (combinational):
  - 1 when cpu_req is high and no completion is being delivered this cycle.
  - Deasserts in the cycle after mem_ack for a CPU grant, when cpu_rdata is valid.
  - 0 when cpu_req is low.
- No back-to-back grant to the same requester while the other is waiting. Minimum transaction is 3 cycles (IDLE, BUSY, ack).
- host_rdata and cpu_rdata hold their last value between transactions.
- Reset mid-transaction: mem_req is 0 the cycle after reset. No ack or err is generated for the abandoned transfer.
- A host_req deasserted before host_ack is a protocol violation. The transaction already granted still completes.

Decomposition:
- Package y86_bus_pkg:
  - state enum {IDLE, BUSY_CPU, BUSY_HOST}
  - grant_t {GNT_CPU, GNT_HOST}
  - ERR_DATA default
  - bus width constant 32
- Sub-module y86_arb_rr2: 2-way round-robin picker. Inputs: req[1:0], last_grant. Output: one-hot grant. Purely combinational.
- FSM, timeout counter and registers stay in the top module.

Test Plan:
- CPU read only: cpu_RE=1, cpu_A=0x10; memory acks 2 cycles after mem_req with 0x1234 -> mem_addr=0x10, mem_we=0; cpu_rdata=0x1234; cpu_stall drops the cycle after ack; err=0.
- Host write: host_req=1, host_we=1, addr=0x40, wdata=0xA5A5A5A5 -> mem_we=1, mem_wdata=0xA5A5A5A5; host_ack pulses exactly once; cpu_stall unaffected.
- Simultaneous requests held for 4 transactions, both continuously -> grant order CPU, HOST, CPU, HOST after reset.
- Timeout: host read, mem_ack never asserted -> mem_req drops after TIMEOUT cycles; err=1 for one cycle; host_rdata=0xDEADBEEF; host_ack pulses.
- cpu_RE=cpu_WE=1 -> mem_we=1, err pulses at grant; the transaction completes normally on mem_ack.
- rst asserted while BUSY_CPU with mem_req=1 -> mem_req=0 the next cycle; no cpu completion, no err; the following tie goes to the CPU.

Source files
------------

// File: rtl/y86_bus_pkg.sv
// Shared types and constants for the y86 memory arbiter.
// Bus width, FSM states, grant encoding and abort data.
package y86_bus_pkg;

   localparam int BUS_W = 32;

   localparam logic [BUS_W-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_CPU,
      BUSY_HOST
   } state_t;

   typedef enum logic {
      GNT_CPU,
      GNT_HOST
   } grant_t;

endpackage

// File: rtl/y86_arb_rr2.sv
// Two-way round-robin picker, purely combinational.
// req[0]/grant[0] is the CPU, req[1]/grant[1] the host.
module y86_arb_rr2
   import y86_bus_pkg::*;
(
   input  logic [1:0] req,
   input  grant_t     last_grant,
   output logic [1:0] grant
);

   // On a tie the requester that did not win last time goes first
   always_comb begin
      grant = 2'b00;
      unique case (1'b1)
         (req == 2'b11): grant = (last_grant == GNT_HOST) ? 2'b01 : 2'b10;
         (req == 2'b01): grant = 2'b01;
         (req == 2'b10): grant = 2'b10;
         default:        grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/y86_mem_arbiter.sv
// Shares one memory port between the y86 core and a host port.
// Round-robin grant, registered memory side, per-transfer timeout.
module y86_mem_arbiter
   import y86_bus_pkg::*;
#(
   parameter int               TIMEOUT  = 16,
   parameter logic [BUS_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BUS_W-1:0] cpu_A,
   input  logic             cpu_RE,
   input  logic             cpu_WE,
   input  logic [BUS_W-1:0] cpu_wdata,
   output logic [BUS_W-1:0] cpu_rdata,
   output logic             cpu_stall,
   input  logic             host_req,
   input  logic             host_we,
   input  logic [BUS_W-1:0] host_addr,
   input  logic [BUS_W-1:0] host_wdata,
   output logic [BUS_W-1:0] host_rdata,
   output logic             host_ack,
   output logic             mem_req,
   output logic             mem_we,
   output logic [BUS_W-1:0] mem_addr,
   output logic [BUS_W-1:0] mem_wdata,
   input  logic [BUS_W-1:0] mem_rdata,
   input  logic             mem_ack,
   output logic             err
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   state_t        state_q, state_d;
   grant_t        last_grant;
   logic [CW-1:0] cnt;
   logic          cpu_done;
   logic          cpu_req;
   logic [1:0]    req, gnt;
   logic          start, ack_ok, abort;

   assign cpu_req = cpu_RE | cpu_WE;

   // A requester whose completion is being delivered this cycle
   // is still holding its request; mask it so it is not re-granted.
   assign req = {host_req & ~host_ack, cpu_req & ~cpu_done};

   assign cpu_stall = cpu_req & ~cpu_done;

   y86_arb_rr2 u_rr (
      .req        (req),
      .last_grant (last_grant),
      .grant      (gnt)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state: grant from IDLE, leave BUSY on ack or timeout
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      ack_ok  = 1'b0;
      abort   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (gnt[0]) begin
               start   = 1'b1;
               state_d = BUSY_CPU;
            end else if (gnt[1]) begin
               start   = 1'b1;
               state_d = BUSY_HOST;
            end
         end
         BUSY_CPU, BUSY_HOST: begin
            if (mem_ack) begin
               ack_ok  = 1'b1;
               state_d = IDLE;
            end else if (cnt == LAST) begin
               abort   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Memory-side registers, completion pulses and timeout counter
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cpu_rdata  <= '0;
         host_rdata <= '0;
         host_ack   <= 1'b0;
         err        <= 1'b0;
         cpu_done   <= 1'b0;
         last_grant <= GNT_HOST;
         cnt        <= '0;
      end else begin
         err      <= 1'b0;
         host_ack <= 1'b0;
         cpu_done <= 1'b0;
         if (start) begin
            mem_req <= 1'b1;
            cnt     <= '0;
            if (gnt[0]) begin
               last_grant <= GNT_CPU;
               mem_addr   <= cpu_A;
               mem_we     <= cpu_WE;
               mem_wdata  <= cpu_wdata;
               err        <= cpu_RE & cpu_WE;
            end else begin
               last_grant <= GNT_HOST;
               mem_addr   <= host_addr;
               mem_we     <= host_we;
               mem_wdata  <= host_wdata;
            end
         end else if (ack_ok || abort) begin
            mem_req <= 1'b0;
            err     <= abort;
            if (state_q == BUSY_CPU) begin
               cpu_done <= 1'b1;
               if (!mem_we)
                  cpu_rdata <= ack_ok ? mem_rdata : ERR_DATA;
            end else begin
               host_ack <= 1'b1;
               if (!mem_we)
                  host_rdata <= ack_ok ? mem_rdata : ERR_DATA;
            end
         end else if (state_q != IDLE) begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Directed self-checking bench for y86_mem_arbiter.
// A small memory responder acks after a set number of mem_req cycles.
module tb_y86_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] cpu_A, cpu_wdata, cpu_rdata;
   logic        cpu_RE, cpu_WE, cpu_stall;
   logic        host_req, host_we, host_ack;
   logic [31:0] host_addr, host_wdata, host_rdata;
   logic        mem_req, mem_we, mem_ack, err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int          n_chk = 0;
   int          n_err = 0;
   int          lat = 2;
   bit          mem_on = 1'b1;
   int          age = 0;
   logic [31:0] rd_val = 32'h0;
   logic [31:0] gq[$];

   always #5 clk = ~clk;

   assign mem_rdata = rd_val;

   y86_mem_arbiter #(.TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_A      (cpu_A),
      .cpu_RE     (cpu_RE),
      .cpu_WE     (cpu_WE),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .host_req   (host_req),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_rdata (host_rdata),
      .host_ack   (host_ack),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .err        (err)
   );

   // Memory model: ack in the lat-th cycle that mem_req is high
   initial begin
      mem_ack = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (mem_req) age = age + 1;
         else         age = 0;
         if (age == 1) gq.push_back(mem_addr);
         mem_ack = mem_on && (age == lat);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      int k;
      int acks;
      rst = 1'b1;
      cpu_A = '0; cpu_RE = 0; cpu_WE = 0; cpu_wdata = '0;
      host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
      do_reset();

      // reset state
      chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_cpu_rdata", cpu_rdata, 32'h0);
      chk("rst_host_rdata", host_rdata, 32'h0);
      chk("rst_host_ack", {31'b0, host_ack}, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      chk("rst_stall", {31'b0, cpu_stall}, 32'd0);

      // CPU read, memory acks in 2nd mem_req cycle
      lat = 2; mem_on = 1; rd_val = 32'h1234;
      cpu_RE = 1; cpu_A = 32'h10;
      #1;
      chk("rd_stall_req", {31'b0, cpu_stall}, 32'd1);
      cyc();
      chk("rd_mem_req", {31'b0, mem_req}, 32'd1);
      chk("rd_mem_addr", mem_addr, 32'h10);
      chk("rd_mem_we", {31'b0, mem_we}, 32'd0);
      cyc();
      chk("rd_stall_busy", {31'b0, cpu_stall}, 32'd1);
      cyc();
      chk("rd_cpu_rdata", cpu_rdata, 32'h1234);
      chk("rd_stall_done", {31'b0, cpu_stall}, 32'd0);
      chk("rd_mem_req_drop", {31'b0, mem_req}, 32'd0);
      chk("rd_err", {31'b0, err}, 32'd0);
      cpu_RE = 0;
      cyc();
      chk("rd_no_regrant", {31'b0, mem_req}, 32'd0);

      // Host write
      host_req = 1; host_we = 1; host_addr = 32'h40;
      host_wdata = 32'hA5A5A5A5;
      cyc();
      chk("hw_mem_we", {31'b0, mem_we}, 32'd1);
      chk("hw_mem_addr", mem_addr, 32'h40);
      chk("hw_mem_wdata", mem_wdata, 32'hA5A5A5A5);
      chk("hw_stall", {31'b0, cpu_stall}, 32'd0);
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (host_ack) begin
            acks++;
            host_req = 0;
         end
      end
      chk("hw_ack_once", acks, 32'd1);
      host_req = 0;

      // Fairness: both request continuously after reset
      do_reset();
      lat = 1; rd_val = 32'h1234;
      gq.delete();
      cpu_RE = 1; cpu_A = 32'h100;
      host_req = 1; host_we = 0; host_addr = 32'h200;
      k = 0;
      while (gq.size() < 4 && k < 40) begin
         cyc();
         k++;
      end
      chk("rr_bound", {31'b0, (gq.size() >= 4)}, 32'd1);
      if (gq.size() >= 4) begin
         chk("rr_g0", gq[0], 32'h100);
         chk("rr_g1", gq[1], 32'h200);
         chk("rr_g2", gq[2], 32'h100);
         chk("rr_g3", gq[3], 32'h200);
      end
      cpu_RE = 0; host_req = 0;
      for (int i = 0; i < 6; i++) cyc();

      // Timeout on a host read
      mem_on = 0;
      host_req = 1; host_we = 0; host_addr = 32'h80;
      cyc();
      chk("to_mem_req", {31'b0, mem_req}, 32'd1);
      k = 0;
      while (mem_req && k < 40) begin
         cyc();
         k++;
         if (mem_req && err) chk("to_early_err", 32'd1, 32'd0);
      end
      chk("to_cycles", k, 32'd16);
      chk("to_err", {31'b0, err}, 32'd1);
      chk("to_host_ack", {31'b0, host_ack}, 32'd1);
      chk("to_host_rdata", host_rdata, 32'hDEADBEEF);
      host_req = 0;
      cyc();
      chk("to_err_pulse", {31'b0, err}, 32'd0);
      chk("to_ack_pulse", {31'b0, host_ack}, 32'd0);
      mem_on = 1;

      // cpu_RE and cpu_WE together: write plus err
      lat = 2; rd_val = 32'h9999;
      cpu_RE = 1; cpu_WE = 1; cpu_A = 32'h20; cpu_wdata = 32'h55;
      cyc();
      chk("rw_mem_we", {31'b0, mem_we}, 32'd1);
      chk("rw_mem_wdata", mem_wdata, 32'h55);
      chk("rw_err", {31'b0, err}, 32'd1);
      cyc();
      chk("rw_err_pulse", {31'b0, err}, 32'd0);
      chk("rw_stall_busy", {31'b0, cpu_stall}, 32'd1);
      cyc();
      chk("rw_done_stall", {31'b0, cpu_stall}, 32'd0);
      chk("rw_mem_req_drop", {31'b0, mem_req}, 32'd0);
      chk("rw_rdata_kept", cpu_rdata, 32'h1234);
      chk("rw_done_err", {31'b0, err}, 32'd0);
      cpu_RE = 0; cpu_WE = 0;
      cyc();

      // Reset while BUSY_CPU
      mem_on = 0;
      cpu_RE = 1; cpu_A = 32'h30;
      cyc();
      chk("mr_mem_req", {31'b0, mem_req}, 32'd1);
      cyc();
      rst = 1;
      cyc();
      chk("mr_mem_req_drop", {31'b0, mem_req}, 32'd0);
      chk("mr_err", {31'b0, err}, 32'd0);
      chk("mr_stall", {31'b0, cpu_stall}, 32'd1);
      chk("mr_cpu_rdata", cpu_rdata, 32'h0);
      rst = 0;
      mem_on = 1; lat = 2;
      host_req = 1; host_we = 0; host_addr = 32'h300;
      cyc();
      chk("mr_tie_addr", mem_addr, 32'h30);
      chk("mr_tie_we", {31'b0, mem_we}, 32'd0);
      cpu_RE = 0; host_req = 0;
      for (int i = 0; i < 8; i++) cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
